// File: rtl/pattern_seq.sv
// pattern_seq: stitch-start configuration sequencer for the hitomezashi painter.
// Keeps an active copy of the vertical/horizontal stitch-start vectors, which the
// painter sees, and a shadow copy. The host fills the shadow in CHUNKW-bit chunks,
// or an internal LFSR refills it every auto_period frames. The shadow is copied
// into the active registers only on frame_start, so no frame shows a torn pattern.
module pattern_seq #(
  parameter int                VLINES = 40,
  parameter int                HLINES = 30,
  parameter int                CHUNKW = 5,
  parameter logic [VLINES-1:0] V_INIT = '0,
  parameter logic [HLINES-1:0] H_INIT = '0,
  parameter logic [15:0]       SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_sel,
  input  logic [3:0]        cfg_idx,
  input  logic [CHUNKW-1:0] cfg_data,
  input  logic              cfg_commit,
  input  logic [7:0]        auto_period,
  output logic [VLINES-1:0] v_start,
  output logic [HLINES-1:0] h_start,
  output logic              busy,
  output logic              swap
);

  localparam int IDXW  = 4;
  localparam int NV_CH = VLINES / CHUNKW;
  localparam int NH_CH = HLINES / CHUNKW;
  localparam int NCH   = NV_CH + NH_CH;
  localparam int CNTW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CNTW-1:0] NV_CH_C  = CNTW'(NV_CH);
  localparam logic [CNTW-1:0] LAST_CNT = CNTW'(NCH - 1);
  localparam logic [15:0]     LFSR_MASK = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RAND = 2'd1,
    PEND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [15:0]       lfsr_q;
  logic [15:0]       lfsr_next;
  logic [CNTW-1:0]   rand_cnt_q;
  logic [CNTW-1:0]   rand_idx;
  logic              rand_is_h;
  logic              rand_last;
  logic [7:0]        frame_cnt_q;
  logic              auto_hit;
  logic              do_swap;
  logic [VLINES-1:0] shadow_v_q;
  logic [HLINES-1:0] shadow_h_q;
  logic [VLINES-1:0] v_start_q;
  logic [HLINES-1:0] h_start_q;
  logic              swap_q;

  // Shadow write port, shared by host writes and the LFSR refill.
  logic              wr_en;
  logic              wr_sel;
  logic [IDXW-1:0]   wr_idx;
  logic [CHUNKW-1:0] wr_data;

  // Chunk data is MSB-first in line order: data[CHUNKW-1] is the lowest line of
  // the chunk, while vector bit i is line i, so the chunk is bit-reversed.
  function automatic logic [CHUNKW-1:0] chunk_lines(input logic [CHUNKW-1:0] d);
    logic [CHUNKW-1:0] r;
    for (int m = 0; m < CHUNKW; m++) begin
      r[m] = d[CHUNKW-1-m];
    end
    return r;
  endfunction

  assign rand_is_h = (rand_cnt_q >= NV_CH_C);
  assign rand_idx  = rand_is_h ? (rand_cnt_q - NV_CH_C) : rand_cnt_q;
  assign rand_last = (rand_cnt_q == LAST_CNT);
  assign auto_hit  = (auto_period != 8'd0) && (frame_cnt_q == auto_period);
  assign do_swap   = (state_q == PEND) && frame_start;

  // Galois right-shift LFSR step.
  assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_MASK : 16'h0000);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would make results depend on block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: commit beats auto-randomise; RAND always drains into PEND.
  // NOTE: every always_comb output gets a default first, otherwise a path that
  // does not assign it would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cfg_commit) begin
          state_d = PEND;
        end else if (auto_hit) begin
          state_d = RAND;
        end
      end
      RAND: begin
        if (rand_last) begin
          state_d = PEND;
        end
      end
      PEND: begin
        if (frame_start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: the host port is open only while idle.
  always_comb begin
    cfg_ready = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
      end
      default: begin
        cfg_ready = 1'b0;
        busy      = 1'b1;
      end
    endcase
  end

  // Shadow write source: LFSR chunk sequence in RAND, host port in IDLE.
  always_comb begin
    wr_en   = 1'b0;
    wr_sel  = cfg_sel;
    wr_idx  = cfg_idx;
    wr_data = cfg_data;
    if (state_q == RAND) begin
      wr_en   = 1'b1;
      wr_sel  = rand_is_h;
      wr_idx  = IDXW'(rand_idx);
      wr_data = lfsr_q[CHUNKW-1:0];
    end else if (state_q == IDLE) begin
      wr_en = cfg_valid;
    end
  end

  // Shadow vectors; an index past the end of the selected vector matches no chunk
  // and the write is silently dropped.
  // NOTE: the shadow is reset like ordinary state (not left as uninitialised
  // storage) so a reset during a refill discards any partially built pattern.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_v_q <= V_INIT;
      shadow_h_q <= H_INIT;
    end else if (wr_en) begin
      for (int k = 0; k < NV_CH; k++) begin
        if (!wr_sel && (wr_idx == IDXW'(k))) begin
          shadow_v_q[k*CHUNKW +: CHUNKW] <= chunk_lines(wr_data);
        end
      end
      for (int k = 0; k < NH_CH; k++) begin
        if (wr_sel && (wr_idx == IDXW'(k))) begin
          shadow_h_q[k*CHUNKW +: CHUNKW] <= chunk_lines(wr_data);
        end
      end
    end
  end

  // LFSR advances only while it is feeding chunks into the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (state_q == RAND) begin
      lfsr_q <= lfsr_next;
    end
  end

  // Chunk counter for the refill; parked at zero outside RAND.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rand_cnt_q <= '0;
    end else if ((state_q == RAND) && !rand_last) begin
      rand_cnt_q <= rand_cnt_q + 1'b1;
    end else begin
      rand_cnt_q <= '0;
    end
  end

  // Frames seen while idle, saturating; restarts whenever a new pattern goes live.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 8'd0;
    end else if (do_swap) begin
      frame_cnt_q <= 8'd0;
    end else if ((state_q == IDLE) && frame_start && (frame_cnt_q != 8'hFF)) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  // Active vectors and the swap strobe, both updated only at a frame boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_start_q <= V_INIT;
      h_start_q <= H_INIT;
      swap_q    <= 1'b0;
    end else begin
      swap_q <= do_swap;
      if (do_swap) begin
        v_start_q <= shadow_v_q;
        h_start_q <= shadow_h_q;
      end
    end
  end

  assign v_start = v_start_q;
  assign h_start = h_start_q;
  assign swap    = swap_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Testbench for pattern_seq: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a line-level behavioural model.
module tb_pattern_seq;

  localparam int          VLINES = 40;
  localparam int          HLINES = 30;
  localparam int          CHUNKW = 5;
  localparam logic [39:0] V_INIT_TB = 40'h0123456789;
  localparam logic [29:0] H_INIT_TB = 30'h0;
  localparam int          NV_CH = VLINES / CHUNKW;
  localparam int          NH_CH = HLINES / CHUNKW;
  localparam int          NCH   = NV_CH + NH_CH;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_sel;
  logic [3:0]        cfg_idx;
  logic [CHUNKW-1:0] cfg_data;
  logic              cfg_commit;
  logic [7:0]        auto_period;
  logic [VLINES-1:0] v_start;
  logic [HLINES-1:0] h_start;
  logic              busy;
  logic              swap;

  int checks   = 0;
  int failures = 0;

  pattern_seq #(
    .VLINES(VLINES), .HLINES(HLINES), .CHUNKW(CHUNKW),
    .V_INIT(V_INIT_TB), .H_INIT(H_INIT_TB), .SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_sel(cfg_sel),
    .cfg_idx(cfg_idx), .cfg_data(cfg_data), .cfg_commit(cfg_commit),
    .auto_period(auto_period), .v_start(v_start), .h_start(h_start),
    .busy(busy), .swap(swap)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model (per-line arrays) ----------------
  bit          m_sh_v [VLINES];
  bit          m_sh_h [HLINES];
  bit          m_act_v[VLINES];
  bit          m_act_h[HLINES];
  int          m_rand_left;
  bit          m_pending;
  int          m_fcnt;
  bit [15:0]   m_lfsr;
  bit          m_swap;

  task automatic m_reset();
    logic [39:0] vi;
    logic [29:0] hi;
    vi = V_INIT_TB;
    hi = H_INIT_TB;
    for (int i = 0; i < VLINES; i++) begin m_sh_v[i] = vi[i]; m_act_v[i] = vi[i]; end
    for (int i = 0; i < HLINES; i++) begin m_sh_h[i] = hi[i]; m_act_h[i] = hi[i]; end
    m_rand_left = 0;
    m_pending   = 0;
    m_fcnt      = 0;
    m_lfsr      = 16'hACE1;
    m_swap      = 0;
  endtask

  // Chunk k holds lines k*CHUNKW.., first line taken from the data MSB.
  task automatic m_write(input bit is_h, input int idx, input logic [CHUNKW-1:0] d);
    for (int m = 0; m < CHUNKW; m++) begin
      if (!is_h && idx < NV_CH) m_sh_v[idx*CHUNKW + m] = d[CHUNKW-1-m];
      if (is_h && idx < NH_CH)  m_sh_h[idx*CHUNKW + m] = d[CHUNKW-1-m];
    end
  endtask

  task automatic m_step();
    int  j;
    int  old_fcnt;
    bit  lsb;
    m_swap = 0;
    if (m_rand_left > 0) begin
      j = NCH - m_rand_left;
      if (j < NV_CH) m_write(1'b0, j, m_lfsr[CHUNKW-1:0]);
      else           m_write(1'b1, j - NV_CH, m_lfsr[CHUNKW-1:0]);
      lsb    = m_lfsr[0];
      m_lfsr = m_lfsr >> 1;
      if (lsb) m_lfsr = m_lfsr ^ 16'hB400;
      m_rand_left--;
      if (m_rand_left == 0) m_pending = 1;
    end else if (m_pending) begin
      if (frame_start) begin
        for (int i = 0; i < VLINES; i++) m_act_v[i] = m_sh_v[i];
        for (int i = 0; i < HLINES; i++) m_act_h[i] = m_sh_h[i];
        m_swap    = 1;
        m_pending = 0;
        m_fcnt    = 0;
      end
    end else begin
      old_fcnt = m_fcnt;
      if (cfg_valid) m_write(cfg_sel, int'(cfg_idx), cfg_data);
      if (frame_start && m_fcnt < 255) m_fcnt++;
      if (cfg_commit) m_pending = 1;
      else if (auto_period != 8'd0 && old_fcnt == int'(auto_period)) m_rand_left = NCH;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_reset();
    else        m_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    logic [VLINES-1:0] ev;
    logic [HLINES-1:0] eh;
    bit                mbusy;
    if (rst_n === 1'b1) begin
      for (int i = 0; i < VLINES; i++) ev[i] = m_act_v[i];
      for (int i = 0; i < HLINES; i++) eh[i] = m_act_h[i];
      mbusy = (m_rand_left > 0) || m_pending;
      check("model_v_start", 64'(v_start), 64'(ev));
      check("model_h_start", 64'(h_start), 64'(eh));
      check("model_swap", 64'(swap), 64'(m_swap));
      check("model_busy", 64'(busy), 64'(mbusy));
      check("model_cfg_ready", 64'(cfg_ready), 64'(!mbusy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic host_write(input bit sel, input logic [3:0] idx,
                            input logic [CHUNKW-1:0] d, input bit commit);
    cfg_valid  = 1'b1;
    cfg_sel    = sel;
    cfg_idx    = idx;
    cfg_data   = d;
    cfg_commit = commit;
    tick();
    cfg_valid  = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    cfg_valid   = 1'b0;
    cfg_sel     = 1'b0;
    cfg_idx     = 4'd0;
    cfg_data    = '0;
    cfg_commit  = 1'b0;
    auto_period = 8'd0;
    repeat (3) tick();

    // Reset state.
    check("rst_v_start", 64'(v_start), 64'h0123456789);
    check("rst_h_start", 64'(h_start), 64'h0);
    check("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_swap", 64'(swap), 64'd0);
    rst_n = 1'b1;
    tick();

    // Host writes + commit; swap only at the frame_start ten cycles later.
    host_write(1'b0, 4'd0, 5'b10110, 1'b0);
    host_write(1'b1, 4'd5, 5'b00001, 1'b0);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("pend_busy", 64'(busy), 64'd1);
    repeat (10) tick();
    check("pre_swap_v", 64'(v_start), 64'h0123456789);
    pulse_frame();
    check("swap_pulse", 64'(swap), 64'd1);
    check("swap_v", 64'(v_start), 64'h012345678D);
    check("swap_h", 64'(h_start), 64'h20000000);
    tick();
    check("swap_one_cycle", 64'(swap), 64'd0);

    // Write while pending is refused.
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    check("pend_cfg_ready", 64'(cfg_ready), 64'd0);
    host_write(1'b0, 4'd0, 5'b11111, 1'b0);
    pulse_frame();
    check("pend_write_swap", 64'(swap), 64'd1);
    check("pend_write_v", 64'(v_start), 64'h012345678D);

    // Out-of-range indices are dropped; a swap still happens.
    host_write(1'b1, 4'd6, 5'b11111, 1'b0);
    host_write(1'b0, 4'd8, 5'b11111, 1'b1);
    pulse_frame();
    check("oor_swap", 64'(swap), 64'd1);
    check("oor_v", 64'(v_start), 64'h012345678D);
    check("oor_h", 64'(h_start), 64'h20000000);

    // Auto-randomise after two frames; frame_start on the last RAND edge is ignored.
    auto_period = 8'd2;
    pulse_frame();
    tick();
    pulse_frame();
    check("auto_not_yet", 64'(busy), 64'd0);
    tick();
    check("auto_rand_busy", 64'(busy), 64'd1);
    check("auto_rand_ready", 64'(cfg_ready), 64'd0);
    repeat (13) tick();
    frame_start = 1'b1;
    tick();
    check("rand_fs_ignored", 64'(swap), 64'd0);
    tick();
    frame_start = 1'b0;
    auto_period = 8'd0;
    check("rand_swap", 64'(swap), 64'd1);
    check("rand_v_low", 64'(v_start[9:0]), 64'h030);

    // Reset in the middle of a refill.
    auto_period = 8'd2;
    pulse_frame();
    tick();
    pulse_frame();
    tick();
    repeat (7) tick();
    rst_n = 1'b0;
    #1;
    check("midrst_v", 64'(v_start), 64'h0123456789);
    check("midrst_h", 64'(h_start), 64'h0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_ready", 64'(cfg_ready), 64'd1);
    auto_period = 8'd0;
    tick();
    tick();
    rst_n = 1'b1;
    pulse_frame();
    check("postrst_no_swap", 64'(swap), 64'd0);
    repeat (3) tick();
    // LFSR restarted from SEED: a fresh refill reproduces the first chunks.
    auto_period = 8'd1;
    pulse_frame();
    tick();
    auto_period = 8'd0;
    repeat (14) tick();
    pulse_frame();
    check("reseed_swap", 64'(swap), 64'd1);
    check("reseed_v_low", 64'(v_start[9:0]), 64'h030);

    // Randomized traffic, with one asynchronous reset part-way.
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 4))
          0: auto_period = 8'd0;
          1: auto_period = 8'd1;
          2: auto_period = 8'd2;
          3: auto_period = 8'd3;
          default: auto_period = 8'($urandom_range(0, 255));
        endcase
      end
      cfg_valid   = 1'($urandom_range(0, 1));
      cfg_sel     = 1'($urandom_range(0, 1));
      cfg_idx     = 4'($urandom_range(0, 15));
      cfg_data    = CHUNKW'($urandom);
      cfg_commit  = ($urandom_range(0, 15) == 0);
      frame_start = ($urandom_range(0, 7) == 0);
      if (c == 2000) begin
        rst_n = 1'b0;
        #4;
        rst_n = 1'b1;
      end
      tick();
    end
    cfg_valid   = 1'b0;
    cfg_commit  = 1'b0;
    frame_start = 1'b0;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
